mem_arbiter: RTL and testbench

Two-port arbiter and sequencer sitting in front of the shared memory unit (ROM at 0x0001_0000–0x000F_FFFF, RAM at 0x0010_0000–0xFF0F_FFFF). It shares the single memory port between the instruction-fetch requester (I) and the load/store requester (D) using round-robin arbitration. It holds address, write-enable and write data stable for the memory read latency, then returns the read data with a one-cycle valid pulse. Accesses to reserved space, and writes to ROM, never reach memory and complete with an error flag.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and access sequencer for the shared memory port
module mem_arbiter #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic        i_err,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [2:0] LAT = MEM_LATENCY[2:0];

   state_t      state;
   logic        last_i;     // 1 when the most recent grant went to the fetch port
   logic        owner_i;    // owner of the access in flight
   logic        acc_we;
   logic        acc_err;
   logic [2:0]  cnt;

   logic        can_grant;
   logic        grant;
   logic        new_we;
   logic        new_err;
   logic [31:0] new_addr;
   logic [31:0] new_wdata;
   logic [31:0] rd_cap;

   // reserved space (below ROM, above RAM) and ROM writes are refused
   function automatic logic addr_err(input logic [31:0] a, input logic we);
      logic [15:0] hi;
      hi = a[31:16];
      return (hi == 16'h0000) || (hi >= 16'hFF10) || (we && (hi <= 16'h000F));
   endfunction

   // round-robin grant: only between accesses, tie goes to whoever did not win last
   always_comb begin
      can_grant = rst && (state != ACCESS);
      i_gnt     = can_grant && i_req && (!d_req || !last_i);
      d_gnt     = can_grant && d_req && !i_gnt;
   end

   // fields of the request being granted and the value captured at the end of an access
   always_comb begin
      grant     = i_gnt || d_gnt;
      new_addr  = i_gnt ? i_addr : d_addr;
      new_we    = d_gnt && d_we;
      // the fetch port has no write data, so a fetch grant latches zero
      new_wdata = i_gnt ? 32'h0 : d_wdata;
      new_err   = addr_err(new_addr, new_we);
      rd_cap    = (acc_we || acc_err) ? 32'h0 : mem_rdata;
   end

   assign busy = (state == ACCESS);

   // sequencer: latch on grant, hold for the memory latency, then one response cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last_i    <= 1'b0;
         owner_i   <= 1'b0;
         acc_we    <= 1'b0;
         acc_err   <= 1'b0;
         cnt       <= 3'd0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         i_rdata   <= 32'h0;
         d_rdata   <= 32'h0;
         i_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
         i_err     <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         mem_we   <= 1'b0;
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         i_err    <= 1'b0;
         d_err    <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (grant) begin
                  state     <= ACCESS;
                  owner_i   <= i_gnt;
                  last_i    <= i_gnt;
                  acc_we    <= new_we;
                  acc_err   <= new_err;
                  mem_addr  <= new_addr;
                  mem_wdata <= new_wdata;
                  mem_we    <= new_we && !new_err;
                  cnt       <= 3'd1;
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               cnt <= cnt + 3'd1;
               if (cnt == LAT) begin
                  state <= RESP;
                  if (owner_i) begin
                     i_rvalid <= 1'b1;
                     i_err    <= acc_err;
                     i_rdata  <= rd_cap;
                  end else begin
                     d_rvalid <= 1'b1;
                     d_err    <= acc_err;
                     d_rdata  <= rd_cap;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter at latencies 1 and 3
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // index 0: MEM_LATENCY = 1, index 1: MEM_LATENCY = 3
   logic        rst [2];
   logic        i_req [2], i_gnt [2], i_rvalid [2], i_err [2];
   logic        d_req [2], d_we [2], d_gnt [2], d_rvalid [2], d_err [2];
   logic        mem_we [2], busy [2];
   logic [31:0] i_addr [2], i_rdata [2], d_addr [2], d_wdata [2], d_rdata [2];
   logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];

   mem_arbiter #(.MEM_LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst[0]),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]),
      .i_err(i_err[0]), .i_rdata(i_rdata[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_err(d_err[0]), .d_rdata(d_rdata[0]),
      .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0])
   );

   mem_arbiter #(.MEM_LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst[1]),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]),
      .i_err(i_err[1]), .i_rdata(i_rdata[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_err(d_err[1]), .d_rdata(d_rdata[1]),
      .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1])
   );

   // initial memory contents; word 1 holds the ROM test word
   function automatic logic [31:0] pat(input int i);
      logic [7:0] b;
      b = i[7:0];
      return (i == 1) ? 32'hDEADBEEF : {b, ~b, b ^ 8'h5A, 8'hC3};
   endfunction

   // memory device: 256 words per instance, indexed by address bits [9:2]
   logic [31:0] dev [2][256];
   assign mem_rdata[0] = dev[0][mem_addr[0][9:2]];
   assign mem_rdata[1] = dev[1][mem_addr[1][9:2]];
   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 256; i++) dev[k][i] = pat(i);
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++)
            if (mem_we[k] === 1'b1) dev[k][mem_addr[k][9:2]] <= mem_wdata[k];
      end
   end

   int cyc = 0;
   initial forever begin @(posedge clk); cyc++; end

   int we_cnt [2];
   initial begin
      we_cnt[0] = 0; we_cnt[1] = 0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) if (mem_we[k] === 1'b1) we_cnt[k]++;
      end
   end

   // observations made by the stimulus, compared by the checker process
   string       obs_nm  [256];
   logic [31:0] obs_act [256];
   logic [31:0] obs_exp [256];
   int          obs_wr = 0;
   int          obs_rd = 0;

   task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
      obs_nm[obs_wr % 256]  = nm;
      obs_act[obs_wr % 256] = act;
      obs_exp[obs_wr % 256] = exp;
      obs_wr++;
   endtask

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference model: transaction view of each port
   logic [31:0] rm [2][256];
   bit          m_out [2];      // an access is outstanding
   int          m_age [2];      // cycles since its grant edge
   bit          m_li  [2];      // last winner was the fetch port
   bit          c_i [2], c_we [2], c_er [2];
   logic [31:0] c_res [2];
   logic [31:0] e_addr [2], e_wd [2], e_ri [2], e_rd [2];

   task automatic model_step(input int k);
      int          lt, a, ix;
      bit          resp, acc, free_now, wi, wd, we, er;
      logic [31:0] ad;
      lt = (k == 0) ? 1 : 3;
      if (rst[k] !== 1'b1) begin
         chk($sformatf("rst%0d_ctl", k),
             {24'd0, i_gnt[k], d_gnt[k], i_rvalid[k], d_rvalid[k], i_err[k], d_err[k], mem_we[k], busy[k]}, 32'h0);
         chk($sformatf("rst%0d_maddr", k), mem_addr[k], 32'h0);
         chk($sformatf("rst%0d_mwdata", k), mem_wdata[k], 32'h0);
         chk($sformatf("rst%0d_irdata", k), i_rdata[k], 32'h0);
         chk($sformatf("rst%0d_drdata", k), d_rdata[k], 32'h0);
         m_out[k] = 0; m_age[k] = 0; m_li[k] = 0;
         e_addr[k] = 0; e_wd[k] = 0; e_ri[k] = 0; e_rd[k] = 0;
         c_i[k] = 0; c_we[k] = 0; c_er[k] = 0; c_res[k] = 0;
         return;
      end
      a        = m_out[k] ? m_age[k] : 0;
      resp     = m_out[k] && (a == lt + 1);
      acc      = m_out[k] && (a <= lt);
      free_now = !m_out[k] || resp;
      wi       = free_now && i_req[k] && !(d_req[k] && m_li[k]);
      wd       = free_now && d_req[k] && !wi;

      chk($sformatf("gnt%0d", k), {30'd0, i_gnt[k], d_gnt[k]}, {30'd0, wi, wd});
      chk($sformatf("busy%0d", k), busy[k], acc);
      chk($sformatf("mem_we%0d", k), mem_we[k], acc && (a == 1) && c_we[k] && !c_er[k]);
      chk($sformatf("mem_addr%0d", k), mem_addr[k], e_addr[k]);
      chk($sformatf("mem_wdata%0d", k), mem_wdata[k], e_wd[k]);
      chk($sformatf("rvalid%0d", k), {30'd0, i_rvalid[k], d_rvalid[k]},
          {30'd0, resp && c_i[k], resp && !c_i[k]});
      if (resp) chk($sformatf("err%0d", k), c_i[k] ? i_err[k] : d_err[k], c_er[k]);
      chk($sformatf("i_rdata%0d", k), i_rdata[k], e_ri[k]);
      chk($sformatf("d_rdata%0d", k), d_rdata[k], e_rd[k]);

      if (resp) begin
         m_out[k] = 0;
      end else if (m_out[k]) begin
         m_age[k]++;
         if (m_age[k] == lt + 1) begin
            if (c_i[k]) e_ri[k] = c_res[k];
            else        e_rd[k] = c_res[k];
         end
      end
      if (wi || wd) begin
         ad = wi ? i_addr[k] : d_addr[k];
         we = wd && d_we[k];
         er = (ad < 32'h0001_0000) || (ad >= 32'hFF10_0000) || (we && ad < 32'h0010_0000);
         ix = int'(ad[9:2]);
         c_i[k]  = wi;
         c_we[k] = we;
         c_er[k] = er;
         c_res[k] = (!er && !we) ? rm[k][ix] : 32'h0;
         e_addr[k] = ad;
         e_wd[k]   = wi ? 32'h0 : d_wdata[k];
         if (!er && we) rm[k][ix] = d_wdata[k];
         m_out[k] = 1;
         m_age[k] = 1;
         m_li[k]  = wi;
      end
   endtask

   // the single compare process
   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 256; i++) rm[k][i] = pat(i);
      forever begin
         @(negedge clk);
         while (obs_rd != obs_wr) begin
            chk(obs_nm[obs_rd % 256], obs_act[obs_rd % 256], obs_exp[obs_rd % 256]);
            obs_rd++;
         end
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic do_req(input int k, input bit is_i, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output bit er, output int bcnt, output bit astab);
      int tg, tr;
      tg = -1; tr = -1; rd = 32'h0; er = 0; bcnt = 0; astab = 1; lat = -1;
      step();
      if (is_i) begin
         i_req[k] = 1; i_addr[k] = addr;
      end else begin
         d_req[k] = 1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
      end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (is_i ? i_gnt[k] : d_gnt[k]) begin tg = cyc; break; end
      end
      step();
      if (is_i) i_req[k] = 0; else d_req[k] = 0;
      if (tg < 0) begin post("gnt_timeout", 32'h0, 32'h1); return; end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (busy[k]) begin
            bcnt++;
            if (mem_addr[k] !== addr) astab = 0;
         end
         if (is_i ? i_rvalid[k] : d_rvalid[k]) begin
            tr = cyc;
            rd = is_i ? i_rdata[k] : d_rdata[k];
            er = is_i ? i_err[k] : d_err[k];
            break;
         end
      end
      if (tr < 0) post("rvalid_timeout", 32'h0, 32'h1);
      else lat = tr - tg;
   endtask

   function automatic logic [31:0] raddr();
      logic [31:0] lo;
      lo = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      case ($urandom_range(0, 6))
         0:       return 32'h0000_FC00 | lo;
         1:       return 32'h0001_0000 | lo;
         2, 3:    return 32'h0010_0000 | lo;
         4:       return 32'hFF0F_FC00 | lo;
         5:       return 32'h000F_FC00 | lo;
         default: return 32'hFF10_0000 | lo;
      endcase
   endfunction

   task automatic rnd(input int k, input int ncyc);
      bit gi, gd;
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         gi = i_gnt[k];
         gd = d_gnt[k];
         step();
         if (!i_req[k] || gi) begin
            i_req[k]  = ($urandom_range(0, 2) != 0);
            i_addr[k] = raddr();
         end
         if (!d_req[k] || gd) begin
            d_req[k]   = ($urandom_range(0, 2) != 0);
            d_we[k]    = 1'($urandom_range(0, 1));
            d_addr[k]  = raddr();
            d_wdata[k] = $urandom();
         end
      end
      step();
      i_req[k] = 0;
      d_req[k] = 0;
      idle(8);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      int          lat, bcnt, w0, n_g, prev, sp, smin, smax, cnt;
      logic [31:0] rd;
      logic [7:0]  seq;
      bit          er, astab;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 0; i_req[k] = 0; d_req[k] = 0; d_we[k] = 0;
         i_addr[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1;
      rst[1] = 1;
      idle(2);

      // latency 1: ROM fetch
      do_req(0, 1, 0, 32'h0001_0004, 32'h0, lat, rd, er, bcnt, astab);
      post("rom_lat", lat, 2);
      post("rom_data", rd, 32'hDEADBEEF);
      post("rom_err", er, 0);

      // write then read back
      w0 = we_cnt[0];
      do_req(0, 0, 1, 32'h0010_0008, 32'h1234_5678, lat, rd, er, bcnt, astab);
      post("wr_we_pulses", we_cnt[0] - w0, 1);
      post("wr_err", er, 0);
      do_req(0, 0, 0, 32'h0010_0008, 32'h0, lat, rd, er, bcnt, astab);
      post("rd_back", rd, 32'h1234_5678);
      idle(3);

      // both requesting: I wins first tie, then strict alternation
      step();
      i_req[0] = 1; i_addr[0] = 32'h0010_0010;
      d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h0010_0014;
      n_g = 0; seq = 0; prev = -1; smin = 99; smax = 0;
      for (int n = 0; n < 60 && n_g < 8; n++) begin
         @(negedge clk);
         if (i_gnt[0] || d_gnt[0]) begin
            seq = {seq[6:0], i_gnt[0]};
            if (prev >= 0) begin
               sp = cyc - prev;
               if (sp < smin) smin = sp;
               if (sp > smax) smax = sp;
            end
            prev = cyc;
            n_g++;
         end
      end
      step();
      i_req[0] = 0;
      d_req[0] = 0;
      post("alt_count", n_g, 8);
      post("alt_order", seq, 8'b1010_1010);
      post("alt_space_min", smin, 2);
      post("alt_space_max", smax, 2);
      idle(3);

      // refused accesses
      w0 = we_cnt[0];
      do_req(0, 0, 1, 32'h0002_0000, 32'h1111_2222, lat, rd, er, bcnt, astab);
      post("romwr_err", er, 1); post("romwr_data", rd, 0); post("romwr_lat", lat, 2);
      do_req(0, 0, 0, 32'h0000_0010, 32'h0, lat, rd, er, bcnt, astab);
      post("rsvlo_err", er, 1); post("rsvlo_data", rd, 0); post("rsvlo_lat", lat, 2);
      do_req(0, 0, 0, 32'hFF10_0000, 32'h0, lat, rd, er, bcnt, astab);
      post("rsvhi_err", er, 1); post("rsvhi_data", rd, 0); post("rsvhi_lat", lat, 2);
      post("err_we_pulses", we_cnt[0] - w0, 0);

      // latency 3: single read
      do_req(1, 0, 0, 32'h0010_0000, 32'h0, lat, rd, er, bcnt, astab);
      post("l3_lat", lat, 4);
      post("l3_busy", bcnt, 3);
      post("l3_addr_stable", astab, 1);
      post("l3_data", rd, 32'h00FF_5AC3);

      // reset in the middle of an access
      step();
      d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h0010_0004;
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (d_gnt[1]) begin lat = 0; break; end
      end
      post("mid_gnt_seen", lat, 0);
      step();
      d_req[1] = 0;
      step();
      rst[1] = 0;
      #1;
      post("mid_rst_ctl", {24'd0, i_gnt[1], d_gnt[1], i_rvalid[1], d_rvalid[1],
                           i_err[1], d_err[1], mem_we[1], busy[1]}, 0);
      post("mid_rst_maddr", mem_addr[1], 0);
      post("mid_rst_drdata", d_rdata[1], 0);
      idle(2);
      rst[1] = 1;
      cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (d_rvalid[1] || i_rvalid[1]) cnt++;
      end
      post("mid_no_rvalid", cnt, 0);
      do_req(1, 0, 0, 32'h0010_0004, 32'h0, lat, rd, er, bcnt, astab);
      post("post_rst_lat", lat, 4);
      post("post_rst_data", rd, 32'hDEADBEEF);

      // randomized traffic on both latencies
      rnd(0, 400);
      rnd(1, 400);

      idle(4);
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
